// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: fetches MAX_DIM words from the operand file and re-emits
// their elements as a diagonal wavefront, lane j delayed by j+1 cycles.
module operand_skew_feeder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BUS_WIDTH  = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic [BUS_WIDTH-1:0]            data_i,
   output logic                            start_send_o,
   output logic [BUS_WIDTH-1:0]            lane_data_o,
   output logic [BUS_WIDTH/DATA_WIDTH-1:0] lane_valid_o,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int unsigned MaxDim = BUS_WIDTH / DATA_WIDTH;
   localparam int unsigned CntW   = $clog2(MaxDim) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MaxDim - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFetch = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            fetch;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StFetch;
               cnt_d   = '0;
            end
         end
         StFetch: begin
            if (cnt_q == CntLast) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDrain: begin
            if (cnt_q == CntLast) begin
               state_d = StIdle;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Decoded straight from the state register so the operand file sees a clean
   // low as soon as DRAIN begins or reset is asserted.
   assign fetch        = (state_q == StFetch);
   assign start_send_o = fetch;
   assign busy_o       = (state_q == StFetch) || (state_q == StDrain);
   assign done_o       = done_q;

   for (genvar j = 0; j < MaxDim; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] dat_q [j+1];
      logic                  vld_q [j+1];

      // Stage 0 loads zero/invalid outside FETCH, so bubbles drain as zeros.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s <= j; s++) begin
               dat_q[s] <= '0;
               vld_q[s] <= 1'b0;
            end
         end else begin
            dat_q[0] <= fetch ? data_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
            vld_q[0] <= fetch;
            for (int s = 1; s <= j; s++) begin
               dat_q[s] <= dat_q[s-1];
               vld_q[s] <= vld_q[s-1];
            end
         end
      end

      assign lane_data_o[j*DATA_WIDTH +: DATA_WIDTH] = vld_q[j] ? dat_q[j] : '0;
      assign lane_valid_o[j]                         = vld_q[j];
   end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Bench for operand_skew_feeder: two instances (MAX_DIM=4 and MAX_DIM=2) checked
// each cycle against a run-time based model of the skewed wavefront.
module tb_operand_skew_feeder;

   localparam int MA = 4;
   localparam int MB = 2;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a, start_b;
   logic [31:0] data_a;
   logic [63:0] data_b;
   logic        send_a, send_b, busy_a, busy_b, done_a, done_b;
   logic [31:0] lanes_a;
   logic [63:0] lanes_b;
   logic [3:0]  valid_a;
   logic [1:0]  valid_b;

   logic [63:0] words_a [4];
   logic [63:0] words_b [4];
   logic [63:0] junk = '0;
   int          k_a = 0, k_b = 0;
   int          t_a = -1, t_b = -1;
   int          n_checks = 0, n_pass = 0;
   bit          chk_en = 1'b0;
   bit          pattern = 1'b1;
   int          runs_a = 0;

   always #5 clk_i = ~clk_i;

   operand_skew_feeder #(.DATA_WIDTH(8), .BUS_WIDTH(32)) u_dut_a (
      .clk_i        (clk_i),
      .rst_ni       (rst_n),
      .start_i      (start_a),
      .data_i       (data_a),
      .start_send_o (send_a),
      .lane_data_o  (lanes_a),
      .lane_valid_o (valid_a),
      .busy_o       (busy_a),
      .done_o       (done_a)
   );

   operand_skew_feeder #(.DATA_WIDTH(32), .BUS_WIDTH(64)) u_dut_b (
      .clk_i        (clk_i),
      .rst_ni       (rst_n),
      .start_i      (start_b),
      .data_i       (data_b),
      .start_send_o (send_b),
      .lane_data_o  (lanes_b),
      .lane_valid_o (valid_b),
      .busy_o       (busy_b),
      .done_o       (done_b)
   );

   // Operand file model: presents word k in the k-th start_send cycle, noise otherwise.
   assign data_a = (send_a && k_a < 4) ? words_a[k_a][31:0] : junk[31:0];
   assign data_b = (send_b && k_b < 4) ? words_b[k_b] : junk;

   always @(negedge clk_i) junk <= {$urandom(), $urandom()};

   // t = cycles since the accepted start; -1 when idle. Starts are taken only when
   // idle or in the done cycle (t == 2m).
   function automatic int next_t(int t, logic s, int m);
      if (t >= 0 && t < 2 * m) return t + 1;
      if (s) return 0;
      return -1;
   endfunction

   function automatic logic [63:0] exp_lanes(int m, int dw, int t, logic [63:0] w [4]);
      logic [63:0] r    = '0;
      logic [63:0] mask = (64'd1 << dw) - 64'd1;
      for (int j = 0; j < m; j++)
         if (t >= j + 1 && t <= j + m) r |= w[t-j-1] & (mask << (j * dw));
      return r;
   endfunction

   function automatic logic [63:0] exp_valid(int m, int t);
      logic [63:0] r = '0;
      for (int j = 0; j < m; j++)
         if (t >= j + 1 && t <= j + m) r[j] = 1'b1;
      return r;
   endfunction

   always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         t_a <= -1;
         t_b <= -1;
         k_a <= 0;
         k_b <= 0;
      end else begin
         t_a <= next_t(t_a, start_a, MA);
         t_b <= next_t(t_b, start_b, MB);
         k_a <= send_a ? k_a + 1 : 0;
         k_b <= send_b ? k_b + 1 : 0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_all_zero(input string p);
      check_eq({p, "_a_send"},  64'(send_a),  '0);
      check_eq({p, "_a_busy"},  64'(busy_a),  '0);
      check_eq({p, "_a_done"},  64'(done_a),  '0);
      check_eq({p, "_a_valid"}, 64'(valid_a), '0);
      check_eq({p, "_a_data"},  64'(lanes_a), '0);
      check_eq({p, "_b_send"},  64'(send_b),  '0);
      check_eq({p, "_b_busy"},  64'(busy_b),  '0);
      check_eq({p, "_b_done"},  64'(done_b),  '0);
      check_eq({p, "_b_valid"}, 64'(valid_b), '0);
      check_eq({p, "_b_data"},  lanes_b,      '0);
   endtask

   task automatic set_pattern();
      for (int k = 0; k < 4; k++) begin
         words_a[k] = '0;
         words_b[k] = '0;
         for (int e = 0; e < 4; e++) words_a[k][e*8 +: 8] = 8'(k * 16 + e);
         for (int e = 0; e < 2; e++) words_b[k][e*32 +: 32] = 32'(k * 16 + e);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_n && chk_en) begin
         check_eq("a_send",  64'(send_a),  64'(t_a >= 0 && t_a < MA));
         check_eq("a_busy",  64'(busy_a),  64'(t_a >= 0 && t_a < 2 * MA));
         check_eq("a_done",  64'(done_a),  64'(t_a == 2 * MA));
         check_eq("a_valid", 64'(valid_a), exp_valid(MA, t_a));
         check_eq("a_data",  64'(lanes_a), exp_lanes(MA, 8, t_a, words_a));
         check_eq("b_send",  64'(send_b),  64'(t_b >= 0 && t_b < MB));
         check_eq("b_busy",  64'(busy_b),  64'(t_b >= 0 && t_b < 2 * MB));
         check_eq("b_done",  64'(done_b),  64'(t_b == 2 * MB));
         check_eq("b_valid", 64'(valid_b), exp_valid(MB, t_b));
         check_eq("b_data",  lanes_b,      exp_lanes(MB, 32, t_b, words_b));
         if (pattern && t_a == 4) begin
            check_eq("diag_t4_data",  64'(lanes_a), 64'h0312_2130);
            check_eq("diag_t4_valid", 64'(valid_a), 64'hf);
         end
         if (pattern && t_a == 2) begin
            check_eq("diag_t2_valid", 64'(valid_a),        64'h3);
            check_eq("diag_t2_hi",    64'(lanes_a[31:16]), 64'h0);
         end
      end
   end

   initial begin
      start_a = 1'b0;
      start_b = 1'b0;
      set_pattern();
      repeat (2) @(negedge clk_i);
      check_all_zero("rst");
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk_i);

      // Single run on both, spurious starts at t=2/6 and a back-to-back start on A.
      start_a = 1'b1;
      start_b = 1'b1;
      @(negedge clk_i);
      start_b = 1'b0;
      for (int c = 0; c < 24; c++) begin
         start_a = (t_a == 2 || t_a == 6);
         if (t_a == 8 && runs_a == 0) begin
            start_a = 1'b1;
            runs_a  = 1;
         end
         @(negedge clk_i);
      end
      start_a = 1'b0;
      @(negedge clk_i);

      // Reset in the middle of a run, then a clean run.
      start_a = 1'b1;
      start_b = 1'b1;
      @(negedge clk_i);
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(negedge clk_i);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_mid");
      @(negedge clk_i);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_i);
      start_a = 1'b1;
      start_b = 1'b1;
      @(negedge clk_i);
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (12) @(negedge clk_i);

      // Randomized traffic with random words, start pulses and occasional resets.
      pattern = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (t_a < 0 || t_a == 2 * MA)
            for (int k = 0; k < 4; k++) words_a[k] = {32'h0, $urandom()};
         if (t_b < 0 || t_b == 2 * MB)
            for (int k = 0; k < 4; k++) words_b[k] = {$urandom(), $urandom()};
         start_a = ($urandom_range(0, 3) == 0);
         start_b = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #3 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         @(negedge clk_i);
      end
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (10) @(negedge clk_i);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
